leb128_decoder: RTL
===================

Name: leb128_decoder

Overview:
- Decodes WebAssembly LEB128 immediates (varuint32/64, varint32/64) from the byte stream fetched out of the code ROM.
- Sits between the ROM fetch stage and the cpu execute stage, and hands the cpu a fully decoded 64-bit immediate plus its encoded length.
- The cpu uses the length to advance its program counter; a malformed encoding raises a flag that the cpu maps onto its trap output.

Parameters:
- MAX_BYTES, 10, hard ceiling on encoded length (64-bit case); 32-bit decodes limit at 5.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin new decode; sampled only in IDLE or ERROR
- is_signed  input  1  varint (1) / varuint (0); latched on start
- is_64  input  1  64-bit (1) / 32-bit (0) target; latched on start
- in_data  input  8  ROM byte
- in_valid  input  1  in_data valid
- in_ready  output  1  decoder accepts byte this cycle
- out_value  output  64  decoded value
- out_len  output  4  bytes consumed (1..10)
- out_valid  output  1  out_value/out_len valid
- out_ready  input  1  cpu consumes result
- error  output  1  malformed encoding

Behaviour:
- Reset (reset=0, async): state=IDLE; out_value=0, out_len=0, out_valid=0, in_ready=0, error=0. The internal accumulator, shift and count are all cleared.
- States: IDLE, ACCUM, DONE, ERROR.
- IDLE: in_ready=0. start=1 latches is_signed and is_64, clears acc/count/error, and moves to ACCUM. A byte presented in the same cycle as start is not consumed.
- ACCUM:
  - in_ready=1.
  - On handshake (in_valid & in_ready): acc |= in_data[6:0] << 7*count; count++.
  - If in_data[7]=0, finalise and go to DONE; out_valid rises the cycle after the terminating handshake (latency 1).
  - If in_data[7]=1 and count reaches the limit (5 or 10), go to ERROR.
  - Throughput is one byte per cycle.
- Finalisation:
  - Signed, last byte bit6=1, and 7*count < 64: fill bits [63:7*count] with 1s.
  - 32-bit target: result truncated to bits [31:0]. Bits [63:32] are a sign-extension of bit31 when signed, zeros when unsigned.
  - out_len = count.
- DONE: out_valid=1, in_ready=0. Outputs stay stable until out_ready=1, then go to IDLE with out_valid=0 next cycle. With out_valid=1 and out_ready=1 in the same cycle, the result is consumed. A start in DONE is ignored.
- ERROR: error=1, in_ready=0, out_valid=0. Held until start (clears error and enters ACCUM) or reset.
- Reset mid-decode: aborts immediately. Partial bytes are lost and no out_valid is produced.
- start while in ACCUM: ignored.

Optional Feature:
- Macro LEB128_STRICT_EN.
- Defined: the final byte at maximum length is checked for bits beyond the target width. Failing the check goes to ERROR instead of DONE.
  - 32-bit unsigned: byte5[6:4] must be 0.
  - 32-bit signed: byte5[6:3] must be all equal.
  - 64-bit unsigned: byte10[6:1] must be 0.
  - 64-bit signed: byte10[6:0] must be 0x00 or 0x7F.
- Undefined: excess bits are silently truncated and the result goes to DONE normally. The overlong (count-limit) error is always present.

Test Plan:
- Unsigned 32-bit, bytes E5 8E 26 -> out_value=624485 (0x98765), out_len=3, out_valid one cycle after the 26 handshake.
- Signed 64-bit 7F -> 0xFFFFFFFFFFFFFFFF, len 1. Signed 32-bit C0 BB 78 -> 0xFFFFFFFFFFFE1DC0 (-123456), len 3.
- Unsigned 32-bit 80 80 80 80 80 00 -> error=1 after the 5th byte; 6th byte not accepted (in_ready=0); start then clears error.
- Unsigned 32-bit FF FF FF FF 1F:
  - With LEB128_STRICT_EN: error=1.
  - Without it: out_value=0xFFFFFFFF, len 5.
  - FF FF FF FF 0F -> 0xFFFFFFFF in both builds.
- Backpressure:
  - Decode 2A, hold out_ready=0 for 3 cycles -> out_value=0x2A, len 1 stable, in_ready=0 throughout.
  - in_valid gaps mid-stream (E5, idle 2 cycles, 8E 26) give the same result as back-to-back bytes.
- Reset pulse (reset=0) after E5 8E -> all outputs zero. A new start followed by 01 yields value 1, len 1.

Source files
------------

// File: rtl/leb128_decoder_if.sv
// Handshake bundle between the ROM fetch stage, the LEB128 decoder and the cpu execute stage.
interface leb128_decoder_if;
    logic        start;
    logic        is_signed;
    logic        is_64;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic        out_valid;
    logic        out_ready;
    logic        error;

    modport master (
        output start, is_signed, is_64, in_data, in_valid, out_ready,
        input  in_ready, out_value, out_len, out_valid, error
    );

    modport slave (
        input  start, is_signed, is_64, in_data, in_valid, out_ready,
        output in_ready, out_value, out_len, out_valid, error
    );
endinterface

// File: rtl/leb128_decoder.sv
// WebAssembly LEB128 immediate decoder (varuint/varint, 32/64-bit), one byte per cycle.
// Optional macro LEB128_STRICT_EN rejects final bytes carrying bits beyond the target width.
module leb128_decoder #(
    parameter int MAX_BYTES = 10
) (
    input  logic             clk,
    input  logic             reset,
    leb128_decoder_if.slave  bus
);
    localparam int LIMIT32 = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t      state_r;
    logic        sgn_r;
    logic        w64_r;
    logic [63:0] acc_r;
    logic [3:0]  count_r;
    logic [63:0] out_value_r;
    logic [3:0]  out_len_r;
    logic        out_valid_r;
    logic        in_ready_r;
    logic        error_r;

    logic [3:0]  count_next_s;
    logic [3:0]  limit_s;
    logic [6:0]  shift_s;
    logic [6:0]  fill_at_s;
    logic [63:0] acc_next_s;
    logic [63:0] value_s;
    logic        at_limit_s;
    logic        strict_bad_s;

    // Sign-fill above the last encoded bit, then fold to the requested target width.
    function automatic logic [63:0] finalise(input logic [63:0] acc, input logic top,
                                             input logic [6:0] fill_at, input logic sgn,
                                             input logic w64);
        logic [63:0] v;
        if (sgn && top && (fill_at < 7'd64)) begin
            v = acc | (~64'd0 << fill_at);
        end else begin
            v = acc;
        end
        if (!w64) begin
            v = sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
        end else begin
            v = v;
        end
        return v;
    endfunction

`ifdef LEB128_STRICT_EN
    // Payload bits of the maximum-length byte that fall outside the target width must be redundant.
    function automatic logic over_width(input logic [6:0] p, input logic sgn, input logic w64);
        logic bad;
        case ({w64, sgn})
            2'b00:   bad = (p[6:4] != 3'd0);
            2'b01:   bad = !((p[6:3] == 4'h0) || (p[6:3] == 4'hF));
            2'b10:   bad = (p[6:1] != 6'd0);
            2'b11:   bad = !((p == 7'h00) || (p == 7'h7F));
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    // Next accumulator, finalised value and limit checks for the byte on the bus.
    always_comb begin
        count_next_s = count_r + 4'd1;
        limit_s      = w64_r ? 4'(MAX_BYTES) : 4'(LIMIT32);
        shift_s      = {3'd0, count_r} * 7'd7;
        fill_at_s    = {3'd0, count_next_s} * 7'd7;
        acc_next_s   = acc_r | ({57'd0, bus.in_data[6:0]} << shift_s);
        at_limit_s   = (count_next_s == limit_s);
        value_s      = finalise(acc_next_s, bus.in_data[6], fill_at_s, sgn_r, w64_r);
`ifdef LEB128_STRICT_EN
        strict_bad_s = at_limit_s && over_width(bus.in_data[6:0], sgn_r, w64_r);
`else
        strict_bad_s = 1'b0;
`endif
    end

    // Decoder FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            sgn_r       <= 1'b0;
            w64_r       <= 1'b0;
            acc_r       <= 64'd0;
            count_r     <= 4'd0;
            out_value_r <= 64'd0;
            out_len_r   <= 4'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ERROR: begin
                    if (bus.start) begin
                        sgn_r      <= bus.is_signed;
                        w64_r      <= bus.is_64;
                        acc_r      <= 64'd0;
                        count_r    <= 4'd0;
                        error_r    <= 1'b0;
                        in_ready_r <= 1'b1;
                        state_r    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid && in_ready_r) begin
                        acc_r   <= acc_next_s;
                        count_r <= count_next_s;
                        if (!bus.in_data[7] && !strict_bad_s) begin
                            out_value_r <= value_s;
                            out_len_r   <= count_next_s;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            state_r     <= DONE;
                        end else if (!bus.in_data[7] || at_limit_s) begin
                            error_r    <= 1'b1;
                            in_ready_r <= 1'b0;
                            state_r    <= ERROR;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_value = out_value_r;
    assign bus.out_len   = out_len_r;
    assign bus.out_valid = out_valid_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.error     = error_r;
endmodule
